// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        ALU_WB,
        BRANCH
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_BGTZ  = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - cycle counter that aborts a memory wait left unanswered too long
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    input  logic leave,
    output logic expired
);

    localparam bit             ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // cnt_q holds the number of earlier wait cycles, so expiry lands on wait cycle TIMEOUT_CYCLES
    assign expired = ENABLED && active && !mem_ready && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (ENABLED && active && !mem_ready && !leave && !expired) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM driving every datapath enable
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err
);

    state_e state_q;
    state_e state_d;
    logic   wait_st;
    logic   expire;

    assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (wait_st),
        .mem_ready(mem_ready),
        .leave    (state_d != state_q),
        .expired  (expire)
    );

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // PC + (imm << 2) lands in ALUOut for a possible branch
                alu_src_b = SRCB_IMM_SH2;
                case (op)
                    OP_RTYPE:                         state_d = EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = EXEC_I;
                    OP_LW, OP_SW:                     state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BGTZ:          state_d = BRANCH;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op == OP_RTYPE);
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                pc_src     = PCSRC_ALUOUT;
                instr_done = 1'b1;
                state_d    = FETCH;
                case (op)
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_write = alu_zero;
                    end
                    OP_BNE: begin
                        alu_op   = ALU_SUB;
                        pc_write = !alu_zero;
                    end
                    default: begin
                        alu_op   = ALU_BGTZ;
                        pc_write = !alu_zero && !alu_sign;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase

        // Abort: withdraw the request so a stuck store never completes
        if (expire) begin
            mem_req   = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            bus_err   = 1'b1;
            state_d   = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - vector-table bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       alu_zero, alu_sign, mem_ready;
    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    logic [19:0] act;
    assign act = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                  instr_done, illegal_op, bus_err};

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        s;
        logic        rdy;
        state_e      st;
        logic [19:0] out;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] mk(logic [5:0] m, logic [1:0] p, logic a,
                                       logic [1:0] b, logic [2:0] o, logic [5:0] t);
        return {m, p, a, b, o, t};
    endfunction

    task automatic add(input logic [5:0] o, input logic z, input logic s, input logic r,
                       input state_e st, input logic [19:0] out);
        vec_t v;
        v.op = o; v.z = z; v.s = s; v.rdy = r; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    logic [19:0] Z, F_WAIT, F_RDY, DEC, DEC_ILL, EXR, WB_R, WB_I, MADDR, MRD, MWB;
    logic [19:0] MWR_WAIT, MWR_RDY, MWR_EXP, BR_EQ_T, BR_EQ_N, BR_GT_T, BR_GT_N;

    initial begin
        Z        = '0;
        F_WAIT   = mk(6'b110000, 2'b00, 1'b0, 2'b01, 3'b000, 6'b000000);
        F_RDY    = mk(6'b110011, 2'b00, 1'b0, 2'b01, 3'b000, 6'b000000);
        DEC      = mk(6'b000000, 2'b00, 1'b0, 2'b11, 3'b000, 6'b000000);
        DEC_ILL  = mk(6'b000000, 2'b00, 1'b0, 2'b11, 3'b000, 6'b000110);
        EXR      = mk(6'b000000, 2'b00, 1'b1, 2'b00, 3'b010, 6'b000000);
        WB_R     = mk(6'b000000, 2'b00, 1'b0, 2'b00, 3'b000, 6'b101100);
        WB_I     = mk(6'b000000, 2'b00, 1'b0, 2'b00, 3'b000, 6'b001100);
        MADDR    = mk(6'b000000, 2'b00, 1'b1, 2'b10, 3'b000, 6'b000000);
        MRD      = mk(6'b110100, 2'b00, 1'b0, 2'b00, 3'b000, 6'b000000);
        MWB      = mk(6'b000000, 2'b00, 1'b0, 2'b00, 3'b000, 6'b011100);
        MWR_WAIT = mk(6'b101100, 2'b00, 1'b0, 2'b00, 3'b000, 6'b000000);
        MWR_RDY  = mk(6'b101100, 2'b00, 1'b0, 2'b00, 3'b000, 6'b000100);
        MWR_EXP  = mk(6'b000100, 2'b00, 1'b0, 2'b00, 3'b000, 6'b000001);
        BR_EQ_T  = mk(6'b000001, 2'b01, 1'b1, 2'b00, 3'b001, 6'b000100);
        BR_EQ_N  = mk(6'b000000, 2'b01, 1'b1, 2'b00, 3'b001, 6'b000100);
        BR_GT_T  = mk(6'b000001, 2'b01, 1'b1, 2'b00, 3'b110, 6'b000100);
        BR_GT_N  = mk(6'b000000, 2'b01, 1'b1, 2'b00, 3'b110, 6'b000100);

        add(OP_RTYPE, 0, 0, 0, IDLE, Z);
        add(OP_RTYPE, 0, 0, 1, FETCH, F_RDY);
        add(OP_RTYPE, 0, 0, 1, DECODE, DEC);
        add(OP_RTYPE, 0, 0, 1, EXEC_R, EXR);
        add(OP_RTYPE, 0, 0, 1, ALU_WB, WB_R);
        foreach (vecs[i]) begin end
        begin
            logic [5:0] iops[4];
            logic [2:0] aops[4];
            iops = '{OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
            aops = '{3'b000, 3'b100, 3'b101, 3'b111};
            for (int i = 0; i < 4; i++) begin
                add(iops[i], 0, 0, 1, FETCH, F_RDY);
                add(iops[i], 0, 0, 1, DECODE, DEC);
                add(iops[i], 0, 0, 1, EXEC_I, mk(6'b0, 2'b00, 1'b1, 2'b10, aops[i], 6'b0));
                add(iops[i], 0, 0, 1, ALU_WB, WB_I);
            end
        end
        for (int i = 0; i < 3; i++) add(OP_LW, 0, 0, 0, FETCH, F_WAIT);
        add(OP_LW, 0, 0, 1, FETCH, F_RDY);
        add(OP_LW, 0, 0, 1, DECODE, DEC);
        add(OP_LW, 0, 0, 1, MEM_ADDR, MADDR);
        for (int i = 0; i < 3; i++) add(OP_LW, 0, 0, 0, MEM_RD, MRD);
        add(OP_LW, 0, 0, 1, MEM_RD, MRD);
        add(OP_LW, 0, 0, 1, MEM_WB, MWB);
        add(OP_SW, 0, 0, 1, FETCH, F_RDY);
        add(OP_SW, 0, 0, 1, DECODE, DEC);
        add(OP_SW, 0, 0, 1, MEM_ADDR, MADDR);
        add(OP_SW, 0, 0, 1, MEM_WR, MWR_RDY);
        begin
            logic [5:0]  bop[7];
            logic        bz[7];
            logic        bs[7];
            logic [19:0] bexp[7];
            bop  = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BGTZ, OP_BGTZ, OP_BGTZ};
            bz   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            bs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            bexp = '{BR_EQ_T, BR_EQ_N, BR_EQ_N, BR_EQ_T, BR_GT_N, BR_GT_T, BR_GT_N};
            for (int i = 0; i < 7; i++) begin
                add(bop[i], 0, 0, 1, FETCH, F_RDY);
                add(bop[i], 0, 0, 1, DECODE, DEC);
                add(bop[i], bz[i], bs[i], 1, BRANCH, bexp[i]);
            end
        end
        add(6'b111111, 0, 0, 1, FETCH, F_RDY);
        add(6'b111111, 0, 0, 1, DECODE, DEC_ILL);
        add(OP_SW, 0, 0, 1, FETCH, F_RDY);
        add(OP_SW, 0, 0, 1, DECODE, DEC);
        add(OP_SW, 0, 0, 1, MEM_ADDR, MADDR);
        for (int i = 0; i < 3; i++) add(OP_SW, 0, 0, 0, MEM_WR, MWR_WAIT);
        add(OP_SW, 0, 0, 0, MEM_WR, MWR_EXP);
        add(OP_SW, 0, 0, 1, FETCH, F_RDY);
        add(OP_SW, 0, 0, 1, DECODE, DEC);
        add(OP_SW, 0, 0, 1, MEM_ADDR, MADDR);
        for (int i = 0; i < 3; i++) add(OP_SW, 0, 0, 0, MEM_WR, MWR_WAIT);
        add(OP_SW, 0, 0, 1, MEM_WR, MWR_RDY);
        add(OP_SW, 0, 0, 1, FETCH, F_RDY);
        add(OP_SW, 0, 0, 1, DECODE, DEC);
        add(OP_SW, 0, 0, 1, MEM_ADDR, MADDR);
        for (int i = 0; i < 2; i++) add(OP_SW, 0, 0, 0, MEM_WR, MWR_WAIT);

        rst_n = 1'b0; op = '0; alu_zero = 1'b0; alu_sign = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(act), 32'(Z));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; alu_zero = vecs[i].z; alu_sign = vecs[i].s; mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d_state", i), 32'(dut.state_q), 32'(vecs[i].st));
            chk($sformatf("row%0d_outputs", i), 32'(act), 32'(vecs[i].out));
            @(posedge clk);
            #1;
        end

        // Third MEM_WR wait cycle: pull reset mid-cycle and look before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(act), 32'(Z));
        chk("async_reset_state", 32'(dut.state_q), 32'(IDLE));
        chk("async_reset_wd", 32'(dut.u_wd.cnt_q), 32'd0);
        @(posedge clk);
        #1;
        chk("held_reset_outputs", 32'(act), 32'(Z));
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("post_reset_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        #2;
        chk("post_reset_fetch", 32'(dut.state_q), 32'(FETCH));
        chk("post_reset_wd", 32'(dut.u_wd.cnt_q), 32'd0);
        chk("post_reset_fetch_out", 32'(act), 32'(F_WAIT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
